// File: rtl/i2c_eeprom_slave_if.sv
// rtl/i2c_eeprom_slave_if.sv - I2C pad levels and byte-RAM port of the EEPROM responder
`timescale 1ns/1ps
interface i2c_eeprom_slave_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       busy;

  modport slave (
    input  scl_in, sda_in, mem_rdata,
    output sda_oe, mem_addr, mem_wdata, mem_we, busy
  );

  modport master (
    output scl_in, sda_in, mem_rdata,
    input  sda_oe, mem_addr, mem_wdata, mem_we, busy
  );
endinterface

// File: rtl/i2c_eeprom_slave.sv
// rtl/i2c_eeprom_slave.sv - oversampled I2C responder presenting a 256-byte EEPROM
`timescale 1ns/1ps
module i2c_eeprom_slave #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_l,
  i2c_eeprom_slave_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_WORD_ADDR, S_WORD_ACK,
    S_WRITE_DATA, S_WRITE_ACK, S_READ_DATA, S_READ_ACK
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, scl_p, sda_s, sda_p;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t     state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shift, shift_nxt;
  logic [7:0] ptr, ptr_nxt;
  logic       rw, rw_nxt;
  logic       ack_phase, ack_phase_nxt;
  logic       sda_oe_r, sda_oe_nxt;
  logic       busy_r, busy_nxt;
  logic       mem_we_r, mem_we_nxt;
  logic [7:0] mem_wdata_r, mem_wdata_nxt;
  logic [7:0] mem_addr_r;
  logic [7:0] byte_in;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // Idle bus is high, so the synchronizers reset high to avoid a phantom edge on release.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_p    <= 1'b1;
      sda_p    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      scl_p    <= scl_s;
      sda_p    <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;
  assign byte_in   = {shift[6:0], sda_s};

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state       <= S_IDLE;
      bit_cnt     <= 3'd7;
      shift       <= 8'h00;
      ptr         <= 8'h00;
      rw          <= 1'b0;
      ack_phase   <= 1'b0;
      sda_oe_r    <= 1'b0;
      busy_r      <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_wdata_r <= 8'h00;
      mem_addr_r  <= 8'h00;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      shift       <= shift_nxt;
      ptr         <= ptr_nxt;
      rw          <= rw_nxt;
      ack_phase   <= ack_phase_nxt;
      sda_oe_r    <= sda_oe_nxt;
      busy_r      <= busy_nxt;
      mem_we_r    <= mem_we_nxt;
      mem_wdata_r <= mem_wdata_nxt;
      mem_addr_r  <= ptr;
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shift_nxt     = shift;
    ptr_nxt       = ptr;
    rw_nxt        = rw;
    ack_phase_nxt = ack_phase;
    sda_oe_nxt    = sda_oe_r;
    busy_nxt      = busy_r;
    mem_we_nxt    = 1'b0;
    mem_wdata_nxt = mem_wdata_r;

    if (start_det) begin
      state_nxt     = S_DEV_ADDR;
      bit_cnt_nxt   = 3'd7;
      ack_phase_nxt = 1'b0;
      sda_oe_nxt    = 1'b0;
      busy_nxt      = 1'b1;
    end else if (stop_det) begin
      state_nxt     = S_IDLE;
      ack_phase_nxt = 1'b0;
      sda_oe_nxt    = 1'b0;
      busy_nxt      = 1'b0;
    end else begin
      case (state)
        S_DEV_ADDR, S_WORD_ADDR, S_WRITE_DATA: begin
          if (scl_rise) begin
            shift_nxt   = byte_in;
            bit_cnt_nxt = bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) begin
              ack_phase_nxt = 1'b0;
              if (state == S_DEV_ADDR) begin
                rw_nxt    = sda_s;
                state_nxt = (byte_in[7:1] == DEV_ADDR) ? S_DEV_ACK : S_IDLE;
              end else if (state == S_WORD_ADDR) begin
                ptr_nxt   = byte_in;
                state_nxt = S_WORD_ACK;
              end else begin
                mem_we_nxt    = 1'b1;
                mem_wdata_nxt = byte_in;
                ptr_nxt       = ptr + 8'd1;
                state_nxt     = S_WRITE_ACK;
              end
            end
          end
        end
        // First fall after the byte starts the ACK, the second one ends it.
        S_DEV_ACK, S_WORD_ACK, S_WRITE_ACK: begin
          if (scl_fall) begin
            if (!ack_phase) begin
              sda_oe_nxt    = 1'b1;
              ack_phase_nxt = 1'b1;
            end else begin
              ack_phase_nxt = 1'b0;
              bit_cnt_nxt   = 3'd7;
              sda_oe_nxt    = 1'b0;
              if (state == S_WORD_ACK && rw) begin
                state_nxt  = S_READ_DATA;
                shift_nxt  = bus.mem_rdata;
                sda_oe_nxt = ~bus.mem_rdata[7];
              end else if (state == S_DEV_ACK) begin
                state_nxt = S_WORD_ADDR;
              end else begin
                state_nxt = S_WRITE_DATA;
              end
            end
          end
        end
        S_READ_DATA: begin
          if (scl_rise) begin
            bit_cnt_nxt = bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) begin
              state_nxt     = S_READ_ACK;
              ptr_nxt       = ptr + 8'd1;
              ack_phase_nxt = 1'b0;
            end
          end else if (scl_fall) begin
            sda_oe_nxt = ~shift[bit_cnt];
          end
        end
        S_READ_ACK: begin
          if (scl_fall) begin
            if (!ack_phase) begin
              sda_oe_nxt    = 1'b0;
              ack_phase_nxt = 1'b1;
            end else begin
              ack_phase_nxt = 1'b0;
              bit_cnt_nxt   = 3'd7;
              state_nxt     = S_READ_DATA;
              shift_nxt     = bus.mem_rdata;
              sda_oe_nxt    = ~bus.mem_rdata[7];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sda_oe    = sda_oe_r;
  assign bus.busy      = busy_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.mem_addr  = mem_addr_r;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// tb/tb_i2c_eeprom_slave.sv - bit-banged I2C master, byte RAM and scoreboard for i2c_eeprom_slave
`timescale 1ns/1ps
module tb_i2c_eeprom_slave;
  localparam int Q = 5;

  typedef struct {
    logic [7:0]  dev;
    logic [7:0]  waddr;
    int          n;
    logic [31:0] d;
    logic        exp_ack;
    logic [31:0] exp_rd;
  } vec_t;

  logic clk = 1'b0;
  logic reset_l;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic [7:0] ram [256];
  logic [7:0] exp_mem [256];
  logic [15:0] exp_q [$];
  logic [15:0] wr_log [1024];
  int wr_cnt = 0;
  int oe_cnt = 0;
  int we_long = 0;
  logic we_prev = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  vec_t tbl [7];

  always #5 clk = ~clk;

  i2c_eeprom_slave_if bus();
  assign bus.scl_in = m_scl;
  assign bus.sda_in = m_sda & ~bus.sda_oe;

  i2c_eeprom_slave #(.DEV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .reset_l(reset_l),
    .bus(bus.slave)
  );

  initial for (int i = 0; i < 256; i++) ram[i] = 8'(i * 37 + 5);

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_log[wr_cnt[9:0]] <= {bus.mem_addr, bus.mem_wdata};
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.mem_we && we_prev) we_long <= we_long + 1;
    we_prev <= bus.mem_we;
    if (bus.sda_oe) oe_cnt <= oe_cnt + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(2 * Q);
    m_sda = 1'b0; tick(2 * Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(2 * Q);
    m_sda = 1'b1; tick(2 * Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    tick(Q);
    m_scl = 1'b1; tick(2 * Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    b = bus.sda_in;
    tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      v[i] = b;
    end
    recv_bit(b);
  endtask

  // The responder keeps transmitting after a NACK; clock until it lets SDA go so a STOP is possible.
  task automatic stop_after_read();
    logic b;
    for (int k = 0; k < 9 && bus.sda_oe; k++) recv_bit(b);
    i2c_stop();
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic ack;
    logic [7:0] b, a;
    int we0, oe0;
    we0 = wr_cnt;
    oe0 = oe_cnt;
    i2c_start();
    check({tag, " busy_after_start"}, 32'(bus.busy), 32'd1);
    send_byte(v.dev, ack);
    check({tag, " dev_ack"}, 32'(ack), 32'(!v.exp_ack));
    send_byte(v.waddr, ack);
    check({tag, " word_ack"}, 32'(ack), 32'(!v.exp_ack));
    if (v.dev[0]) begin
      for (int i = 0; i < v.n; i++) begin
        recv_byte(b);
        check($sformatf("%s rd%0d", tag, i), 32'(b), 32'(v.exp_rd[31-8*i -: 8]));
      end
      stop_after_read();
    end else begin
      for (int i = 0; i < v.n; i++) begin
        b = v.d[31-8*i -: 8];
        send_byte(b, ack);
        check($sformatf("%s data_ack%0d", tag, i), 32'(ack), 32'(!v.exp_ack));
        if (v.exp_ack) begin
          a = v.waddr + 8'(i);
          exp_q.push_back({a, b});
          exp_mem[a] = b;
        end
      end
      i2c_stop();
    end
    check({tag, " busy_after_stop"}, 32'(bus.busy), 32'd0);
    check({tag, " sda_oe_after_stop"}, 32'(bus.sda_oe), 32'd0);
    check({tag, " write_count"}, 32'(wr_cnt - we0), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && we0 + k < wr_cnt; k++)
      check($sformatf("%s write%0d", tag, k), 32'(wr_log[(we0 + k) % 1024]), 32'(exp_q[k]));
    if (!v.exp_ack) check({tag, " sda_oe_never"}, 32'(oe_cnt - oe0), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic ack;
    int we0;
    vec_t rv;
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i * 37 + 5);

    reset_l = 1'b0;
    tick(4);
    reset_l = 1'b1;
    tick(2);
    check("reset sda_oe", 32'(bus.sda_oe), 32'd0);
    check("reset mem_we", 32'(bus.mem_we), 32'd0);
    check("reset mem_addr", 32'(bus.mem_addr), 32'd0);
    check("reset mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);

    tbl[0] = '{8'hA0, 8'h10, 2, 32'h3C5A0000, 1'b1, 32'h0};
    tbl[1] = '{8'hA0, 8'h20, 3, 32'h11223300, 1'b1, 32'h0};
    tbl[2] = '{8'hA1, 8'h20, 3, 32'h0,        1'b1, 32'h11223300};
    tbl[3] = '{8'hA2, 8'h00, 1, 32'h55000000, 1'b0, 32'h0};
    tbl[4] = '{8'hA0, 8'hFF, 2, 32'hAABB0000, 1'b1, 32'h0};
    tbl[5] = '{8'hA1, 8'hFF, 2, 32'h0,        1'b1, 32'hAABB0000};
    tbl[6] = '{8'hA1, 8'h10, 2, 32'h0,        1'b1, 32'h3C5A0000};
    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Abort mid-byte: STOP after four data bits.
    we0 = wr_cnt;
    i2c_start();
    send_byte(8'hA0, ack);
    check("abort dev_ack", 32'(ack), 32'd0);
    send_byte(8'h40, ack);
    check("abort word_ack", 32'(ack), 32'd0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_stop();
    check("abort no_write", 32'(wr_cnt - we0), 32'd0);
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort sda_oe", 32'(bus.sda_oe), 32'd0);
    run_vec('{8'hA0, 8'h40, 1, 32'h77000000, 1'b1, 32'h0}, "after_abort");

    // Reset asserted while the device-address ACK is being driven.
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(tbl[0].dev[i]);
    check("dev_ack driven", 32'(bus.sda_oe), 32'd1);
    @(posedge clk);
    #2 reset_l = 1'b0;
    #1 check("async reset sda_oe", 32'(bus.sda_oe), 32'd0);
    m_scl = 1'b1;
    m_sda = 1'b1;
    tick(3);
    reset_l = 1'b1;
    tick(2 * Q);
    check("post_reset busy", 32'(bus.busy), 32'd0);
    run_vec('{8'hA0, 8'h80, 2, 32'h12340000, 1'b1, 32'h0}, "after_reset");
    run_vec('{8'hA1, 8'h80, 2, 32'h0, 1'b1, 32'h12340000}, "after_reset_rd");

    for (int t = 0; t < 16; t++) begin
      logic [6:0] dev7;
      logic mism;
      rv.dev   = 8'h00;
      rv.d     = $urandom;
      rv.n     = $urandom_range(1, 4);
      rv.waddr = ($urandom_range(0, 3) == 0) ? 8'hFE + 8'($urandom_range(0, 1)) : 8'($urandom);
      rv.exp_rd = 32'h0;
      rv.dev[0] = 1'($urandom_range(0, 1));
      mism = !rv.dev[0] && ($urandom_range(0, 4) == 0);
      dev7 = 7'h50;
      if (mism) begin
        dev7 = 7'($urandom);
        if (dev7 == 7'h50) dev7 = 7'h51;
      end
      rv.dev[7:1] = dev7;
      rv.exp_ack = (dev7 == 7'h50);
      if (rv.dev[0])
        for (int i = 0; i < rv.n; i++) rv.exp_rd[31-8*i -: 8] = exp_mem[8'(rv.waddr + 8'(i))];
      run_vec(rv, $sformatf("rand%0d", t));
    end

    check("mem_we single_cycle", 32'(we_long), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_eeprom_slave.md
# i2c_eeprom_slave

Responder end of the two-wire EEPROM link driven by the PIF-side I2C master. It presents a 256-byte EEPROM to the bus and answers one 7-bit device address. Every transaction carries a device-address byte, then a one-byte word address, then write or read data. It oversamples SCL/SDA on the system clock and accesses an external synchronous byte RAM through a simple memory port.

## Interface
- DEV_ADDR, 7'h50, device address this slave acknowledges
- SYNC_STAGES, 2, synchronizer depth on scl_in/sda_in (≥2)
- clk  in  1  system clock; must be ≥8× SCL frequency
- reset_l  in  1  asynchronous, active-low reset
- scl_in  in  1  bus SCL level
- sda_in  in  1  bus SDA level (pad input)
- sda_oe  out  1  1 = pull SDA low; 0 = release (pad tri-states)
- mem_addr  out  8  RAM byte address
- mem_wdata  out  8  RAM write data
- mem_we  out  1  one-clk write strobe
- mem_rdata  in  8  RAM read data, valid 1 clk after mem_addr changes
- busy  out  1  high from START until STOP/abort

## Operation
- Sync: scl_in/sda_in pass through SYNC_STAGES flops plus one history flop (scl_s/scl_p, sda_s/sda_p).
- Edges: scl_rise = scl_s & ~scl_p; scl_fall = ~scl_s & scl_p.
- START = sda falls while scl_s & scl_p both high; STOP = sda rises under the same condition. The two-sample SCL qualification rejects SDA changes coincident with SCL falling.
- START/STOP override every state. START (incl. repeated) → DEV_ADDR, bit count 7, busy=1. STOP → IDLE, sda_oe=0, busy=0.
- Data sampled on scl_rise, MSB first. sda_oe updated only on scl_fall.
- States:
  - IDLE: wait for START.
  - DEV_ADDR: shift 8 bits; latch rw = bit 0. If [7:1]==DEV_ADDR → DEV_ACK, else IDLE (no ACK, ignore bus until next START).
  - DEV_ACK: sda_oe=1 for one SCL period → WORD_ADDR.
  - WORD_ADDR: shift 8 bits into word pointer. A word-address byte always follows the device byte, in both directions.
  - WORD_ACK: drive ACK. On ack completion → WRITE_DATA if rw=0, else READ_DATA.
  - WRITE_DATA: shift 8 bits. On the 8th scl_rise pulse mem_we with mem_addr=pointer and mem_wdata=byte → WRITE_ACK.
  - WRITE_ACK: drive ACK; pointer += 1 → WRITE_DATA.
  - READ_DATA: byte loaded from mem_rdata before bit 7 is driven. sda_oe = ~bit for each bit. After 8 bits → READ_ACK with sda_oe=0; pointer += 1.
  - READ_ACK: ignore the master's ack bit (companion master always releases SDA) → READ_DATA. Transfer ends only on STOP or repeated START.
- Pointer arithmetic is 8-bit modulo; 0xFF + 1 = 0x00.
- A STOP or START mid-byte discards the partial byte; no mem_we is issued.

## Timing
- Reset values: sda_oe=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, state IDLE. sda_oe clears asynchronously on reset_l low.
- Bus-to-detect latency: SYNC_STAGES+1 clk.
- sda_oe changes on the clk edge after scl_fall is detected. Level holds until the next detected scl_fall.
- ACK: sda_oe=1 from the scl_fall ending bit 8 to the scl_fall ending the 9th clock.
- mem_addr is driven with the pointer in the clk after the word/ack byte completes. The read byte is captured ≥2 clk later, well before the next scl_fall (guaranteed by the 8× clk ratio).
- mem_we is exactly 1 clk wide, coincident with the 8th-bit scl_rise detect + 1 clk.

## Test plan
- Write: START, 0xA0, 0x10, 0x3C, 0x5A, STOP → ACK on all 4 bytes; mem_we pulses (0x10,0x3C) then (0x11,0x5A); busy drops after STOP.
- Read: RAM[0x20..0x22]=0x11,0x22,0x33; START, 0xA1, 0x20, clock 3 bytes with master NACK, STOP → SDA shows 0x11,0x22,0x33; sda_oe=0 after STOP.
- Mismatch: START, 0xA2, 0x00, 0x55, STOP → sda_oe never asserted, no mem_we.
- Wrap: write at word 0xFF data 0xAA, 0xBB → mem_we at 0xFF then 0x00.
- Abort: STOP after 4 data bits → no mem_we, state IDLE, busy=0. A following full write succeeds.
- Reset during DEV_ACK (sda_oe=1) → sda_oe=0 without a clk edge. After release, the next START is decoded normally.
